// File: rtl/mt9v032_pkg.sv
// Shared definitions for the MT9V032 parallel-stream timing recovery block:
// word width, embedded sync prefix and codes, tracker state and decode events.
package mt9v032_pkg;

  localparam int DATA_W = 10;

  localparam logic [DATA_W-1:0] SYNC_PREFIX = 10'h3FF;
  localparam logic [DATA_W-1:0] CODE_FS     = 10'h000;
  localparam logic [DATA_W-1:0] CODE_LS     = 10'h001;
  localparam logic [DATA_W-1:0] CODE_LE     = 10'h002;
  localparam logic [DATA_W-1:0] CODE_FE     = 10'h003;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_FRAME = 2'd1,
    ST_LINE  = 2'd2
  } state_t;

  // One-hot-ish view of what the current word means given the previous one.
  typedef struct packed {
    logic fs;
    logic ls;
    logic le;
    logic fe;
    logic bad;    // code word after a prefix that is not FS/LS/LE/FE
    logic dbl;    // prefix directly after a prefix
    logic pixel;  // neither a prefix nor a code word
  } sync_ev_t;

endpackage

// File: rtl/mt9v032_sync_detect.sv
// Sync-code detector plus the two-word pixel holding pipeline.
// The code word is decoded combinationally against a registered
// "previous word was a prefix" flag, so the framer can act on a code in the
// same cycle it arrives while the pixel before the prefix is still held.
module mt9v032_sync_detect
  import mt9v032_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              train_done,
  input  logic              accept,
  input  logic              sof_mark,
  input  logic              flush,
  output sync_ev_t          ev,
  output logic              vld_p1,
  output logic              sof_p1,
  output logic [DATA_W-1:0] data_p1
);

  logic              pfx_p0;
  logic              vld_p0;
  logic              sof_p0;
  logic [DATA_W-1:0] data_p0;
  logic              is_pfx;

  // Classify the incoming word using the previous-prefix flag.
  always_comb begin
    is_pfx   = (in_data == SYNC_PREFIX);
    ev       = '0;
    ev.dbl   = pfx_p0 & is_pfx;
    ev.pixel = ~pfx_p0 & ~is_pfx;
    if (pfx_p0 && !is_pfx) begin
      case (in_data)
        CODE_FS: ev.fs  = 1'b1;
        CODE_LS: ev.ls  = 1'b1;
        CODE_LE: ev.le  = 1'b1;
        CODE_FE: ev.fe  = 1'b1;
        default: ev.bad = 1'b1;
      endcase
    end
  end

  // Stage p0 -> p1 control: prefix tracking and valid/sof bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pfx_p0 <= 1'b0;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      sof_p0 <= 1'b0;
      sof_p1 <= 1'b0;
    end else begin
      pfx_p0 <= train_done & is_pfx;
      vld_p0 <= ~flush & accept;
      vld_p1 <= ~flush & vld_p0;
      sof_p0 <= sof_mark;
      sof_p1 <= sof_p0;
    end
  end

  // Stage p0 -> p1 data: free-running, qualified by the valid bits.
  always_ff @(posedge clk) begin
    data_p0 <= in_data;
    data_p1 <= data_p0;
  end

endmodule

// File: rtl/mt9v032_timing.sv
// MT9V032 embedded-sync timing recovery: hunts for FS, tracks lines and
// frames, emits pixels with sof/eol/eof markers three clocks after input,
// and flags framing errors. Optional statistics outputs are built when
// MT9V032_TIMING_STATS_EN is defined.
module mt9v032_timing
  import mt9v032_pkg::*;
#(
  parameter int COLS = 752,
  parameter int ROWS = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_train_done,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic              err,
  output logic              locked
`ifdef MT9V032_TIMING_STATS_EN
  ,
  output logic [15:0]       stat_frames,
  output logic [15:0]       stat_errors,
  output logic [9:0]        stat_cols
`endif
);

  localparam int COL_W = $clog2(COLS + 1);
  localparam int ROW_W = $clog2(ROWS + 1);
  localparam logic [COL_W-1:0] COL_END  = COL_W'(COLS);
  localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(ROWS);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  state_t            state, state_nxt;
  logic [COL_W-1:0]  col_cnt;
  logic [ROW_W-1:0]  row_cnt;
  logic              sof_pend;

  sync_ev_t          ev;
  logic              vld_p1, sof_p1;
  logic [DATA_W-1:0] data_p1;

  logic fs_ok, ls_ok, le_ok, fe_ok, abort, err_c, flush, accept, eof_c;

  mt9v032_sync_detect u_sync_detect (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .train_done (in_train_done),
    .accept     (accept),
    .sof_mark   (sof_pend),
    .flush      (flush),
    .ev         (ev),
    .vld_p1     (vld_p1),
    .sof_p1     (sof_p1),
    .data_p1    (data_p1)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_HUNT;
    else        state <= state_nxt;
  end

  // Next state: losing alignment or any framing fault drops back to HUNT.
  always_comb begin
    state_nxt = state;
    if (!in_train_done || abort) begin
      state_nxt = ST_HUNT;
    end else begin
      unique case (state)
        ST_HUNT:  if (fs_ok) state_nxt = ST_FRAME;
        ST_FRAME: if (ls_ok) state_nxt = ST_LINE;
                  else if (fe_ok) state_nxt = ST_HUNT;
        ST_LINE:  if (le_ok) state_nxt = ST_FRAME;
        default:  state_nxt = ST_HUNT;
      endcase
    end
  end

  // Decode of legal/illegal events per state; HUNT ignores all but FS.
  always_comb begin
    fs_ok  = 1'b0;
    ls_ok  = 1'b0;
    le_ok  = 1'b0;
    fe_ok  = 1'b0;
    abort  = 1'b0;
    err_c  = 1'b0;
    accept = 1'b0;
    if (in_train_done) begin
      unique case (state)
        ST_HUNT: fs_ok = ev.fs;
        ST_FRAME: begin
          ls_ok = ev.ls;
          fe_ok = ev.fe & (row_cnt == ROW_END);
          abort = ev.fs | ev.le | ev.bad | (ev.fe & (row_cnt != ROW_END));
        end
        ST_LINE: begin
          accept = ev.pixel;
          le_ok  = ev.le & (col_cnt == COL_END);
          abort  = ev.fs | ev.ls | ev.fe | ev.bad | (ev.le & (col_cnt != COL_END));
        end
        default: abort = 1'b0;
      endcase
      // A doubled prefix is reported but tracking continues on the new prefix.
      err_c = abort | (ev.dbl & (state != ST_HUNT));
    end
    flush  = ~in_train_done | abort;
    eof_c  = le_ok & (row_cnt == ROW_LAST);
    locked = (state != ST_HUNT);
  end

  // Column/row counters (saturating) and pending start-of-frame marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt  <= '0;
      row_cnt  <= '0;
      sof_pend <= 1'b0;
    end else begin
      if (ls_ok)                        col_cnt <= '0;
      else if (accept && col_cnt != '1) col_cnt <= col_cnt + 1'b1;
      if (fs_ok)                        row_cnt <= '0;
      else if (le_ok && row_cnt != '1)  row_cnt <= row_cnt + 1'b1;
      if (fs_ok)       sof_pend <= 1'b1;
      else if (accept) sof_pend <= 1'b0;
    end
  end

  // Output stage: held pixel leaves with eol/eof decided by this cycle's code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= err_c;
      if (flush) begin
        out_valid <= 1'b0;
        out_sof   <= 1'b0;
        out_eol   <= 1'b0;
        out_eof   <= 1'b0;
      end else begin
        out_valid <= vld_p1;
        out_sof   <= vld_p1 & sof_p1;
        out_eol   <= vld_p1 & le_ok;
        out_eof   <= vld_p1 & eof_c;
        if (vld_p1) out_data <= data_p1;
      end
    end
  end

`ifdef MT9V032_TIMING_STATS_EN
  // Wrapping frame/error counters and last measured line length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames <= '0;
      stat_errors <= '0;
      stat_cols   <= '0;
    end else begin
      if (fe_ok) stat_frames <= stat_frames + 16'd1;
      if (err_c) stat_errors <= stat_errors + 16'd1;
      if (in_train_done && state == ST_LINE && ev.le) stat_cols <= 10'(col_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_mt9v032_timing.sv
// Bench for mt9v032_timing: builds a word stream (directed and randomized
// frames with injected faults), predicts every output cycle from a
// stream-level model, then replays the stream against the design. Ends with
// directed asynchronous-reset and, when MT9V032_TIMING_STATS_EN is defined,
// statistics checks. Frame geometry is scaled down to keep runs short.
module tb_mt9v032_timing;

  localparam int COLS    = 16;
  localparam int ROWS    = 5;
  localparam int COL_MAX = (1 << $clog2(COLS + 1)) - 1;
  localparam int ROW_MAX = (1 << $clog2(ROWS + 1)) - 1;
  localparam int MAXN    = 4096;
  localparam logic [9:0] PFX = 10'h3FF;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] in_data;
  logic       in_train_done;
  logic       out_valid, out_sof, out_eol, out_eof, err, locked;
  logic [9:0] out_data;
`ifdef MT9V032_TIMING_STATS_EN
  logic [15:0] stat_frames, stat_errors;
  logic [9:0]  stat_cols;
`endif

  always #5 clk = ~clk;

  mt9v032_timing #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_data       (in_data),
    .in_train_done (in_train_done),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_sof       (out_sof),
    .out_eol       (out_eol),
    .out_eof       (out_eof),
    .err           (err),
    .locked        (locked)
`ifdef MT9V032_TIMING_STATS_EN
    ,
    .stat_frames   (stat_frames),
    .stat_errors   (stat_errors),
    .stat_cols     (stat_cols)
`endif
  );

  // Stimulus stream
  logic [9:0] st_word  [MAXN];
  bit         st_train [MAXN];
  int         n_words;

  // Expected and observed outputs, indexed by sample cycle
  bit         e_vld [MAXN+8], e_sof [MAXN+8], e_eol [MAXN+8], e_eof [MAXN+8];
  bit         e_err [MAXN+8], e_lck [MAXN+8];
  logic [9:0] e_data [MAXN+8];
  bit         o_vld [MAXN+8], o_sof [MAXN+8], o_eol [MAXN+8], o_eof [MAXN+8], o_err [MAXN+8];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [9:0] w, input bit t);
    if (n_words < MAXN) begin
      st_word[n_words]  = w;
      st_train[n_words] = t;
      n_words++;
    end
  endtask

  task automatic send_code(input logic [9:0] c);
    push(PFX, 1'b1);
    push(c, 1'b1);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) push(10'($urandom_range(0, 1022)), 1'b1);
  endtask

  // fault: 1 short line, 2 over-long line (saturates), 3 unknown code,
  // 4 alignment loss, 5 FS mid-line, 6 doubled prefixes before LS,
  // 7 missing row, 8 LS mid-line, anything else a clean frame.
  task automatic gen_frame(input int fault, input bit ramp);
    int bad_row;
    int nrows;
    int len;
    logic [9:0] pix;
    bad_row = $urandom_range(0, ROWS - 1);
    nrows   = (fault == 7) ? ROWS - 1 : ROWS;
    idle($urandom_range(1, 3));
    send_code(10'h000);
    for (int r = 0; r < nrows; r++) begin
      idle($urandom_range(0, 2));
      if (fault == 6 && r == bad_row) begin
        push(PFX, 1'b1);
        push(PFX, 1'b1);
      end
      send_code(10'h001);
      len = COLS;
      if (fault == 1 && r == bad_row) len = COLS - 1;
      if (fault == 2 && r == bad_row) len = COL_MAX + 2;
      for (int c = 0; c < len; c++) begin
        pix = ramp ? 10'((r * COLS + c) % 1023) : 10'($urandom_range(0, 1022));
        push(pix, 1'b1);
        if (r == bad_row && c == len / 2) begin
          case (fault)
            3: send_code(10'h005);
            4: for (int k = 0; k < 3; k++) push(10'($urandom_range(0, 1022)), 1'b0);
            5: send_code(10'h000);
            8: send_code(10'h001);
            default: ;
          endcase
        end
      end
      send_code(10'h002);
    end
    idle($urandom_range(0, 2));
    send_code(10'h003);
  endtask

  task automatic kill(input int n);
    for (int j = n + 1; j <= n + 3; j++) begin
      e_vld[j] = 0; e_sof[j] = 0; e_eol[j] = 0; e_eof[j] = 0;
    end
  endtask

  // Stream-level reference: walks the words, applies the framing rules and
  // schedules each emitted pixel three cycles after it was sampled.
  task automatic run_model();
    int st;  // 0 hunting, 1 between lines, 2 inside a line
    bit pfx, sofp, fault;
    int cols, rows, last_pix;
    logic [9:0] w;
    st = 0; pfx = 0; sofp = 0; cols = 0; rows = 0; last_pix = -10;
    for (int i = 0; i < MAXN + 8; i++) begin
      e_vld[i] = 0; e_sof[i] = 0; e_eol[i] = 0; e_eof[i] = 0;
      e_err[i] = 0; e_lck[i] = 0; e_data[i] = '0;
    end
    for (int n = 0; n < n_words; n++) begin
      w = st_word[n];
      fault = 0;
      if (!st_train[n]) begin
        st = 0;
        kill(n);
      end else if (pfx && w == PFX) begin
        fault = (st != 0);
      end else if (pfx) begin
        if (st == 0) begin
          if (w == 10'h000) begin st = 1; rows = 0; sofp = 1; end
        end else if (w == 10'h001 && st == 1) begin
          st = 2; cols = 0;
        end else if (w == 10'h002 && st == 2 && cols == COLS) begin
          rows = (rows < ROW_MAX) ? rows + 1 : rows;
          if (last_pix == n - 2) begin
            e_eol[n+1] = 1;
            e_eof[n+1] = (rows == ROWS);
          end
          st = 1;
        end else if (w == 10'h003 && st == 1 && rows == ROWS) begin
          st = 0;
        end else begin
          fault = 1; st = 0; kill(n);
        end
      end else if (w != PFX && st == 2) begin
        e_vld[n+3] = 1; e_data[n+3] = w; e_sof[n+3] = sofp; sofp = 0;
        cols = (cols < COL_MAX) ? cols + 1 : cols;
        last_pix = n;
      end
      pfx = st_train[n] && (w == PFX);
      e_err[n+1] = fault;
      e_lck[n+1] = (st != 0);
    end
  endtask

  task automatic play_stream();
    for (int n = 0; n < n_words; n++) begin
      @(negedge clk);
      o_vld[n] = out_valid; o_sof[n] = out_sof; o_eol[n] = out_eol;
      o_eof[n] = out_eof;   o_err[n] = err;
      check_eq($sformatf("valid@%0d", n), out_valid, e_vld[n]);
      if (e_vld[n]) check_eq($sformatf("data@%0d", n), out_data, e_data[n]);
      check_eq($sformatf("sof@%0d", n), out_sof, e_sof[n]);
      check_eq($sformatf("eol@%0d", n), out_eol, e_eol[n]);
      check_eq($sformatf("eof@%0d", n), out_eof, e_eof[n]);
      check_eq($sformatf("err@%0d", n), err, e_err[n]);
      check_eq($sformatf("locked@%0d", n), locked, e_lck[n]);
      in_data       = st_word[n];
      in_train_done = st_train[n];
    end
  endtask

  task automatic drive(input logic [9:0] w);
    @(negedge clk);
    in_data = w;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"},  out_valid, 0);
    check_eq({tag, "_data"},   out_data,  0);
    check_eq({tag, "_sof"},    out_sof,   0);
    check_eq({tag, "_eol"},    out_eol,   0);
    check_eq({tag, "_eof"},    out_eof,   0);
    check_eq({tag, "_err"},    err,       0);
    check_eq({tag, "_locked"}, locked,    0);
  endtask

  initial begin
    int seg_a, seg_b;
    int c_vld, c_sof, c_eol, c_eof, c_err, eof_pos, sof_pos, seen_vld, seen_lck;

    rst_n = 1'b0;
    in_data = '0;
    in_train_done = 1'b0;

    // Stimulus: unaligned idle, a clean ramp frame, directed faults, random frames
    n_words = 0;
    for (int i = 0; i < 4; i++) push(10'($urandom_range(0, 1023)), 1'b0);
    idle(3);
    seg_a = n_words;
    gen_frame(0, 1'b1);
    seg_b = n_words + 4;
    gen_frame(1, 1'b0);
    gen_frame(3, 1'b0);
    gen_frame(4, 1'b0);
    gen_frame(6, 1'b0);
    gen_frame(2, 1'b0);
    gen_frame(0, 1'b0);
    for (int f = 0; f < 14; f++) gen_frame($urandom_range(0, 12), 1'b0);
    idle(8);
    run_model();

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    play_stream();

    // Whole-frame totals for the clean ramp frame
    c_vld = 0; c_sof = 0; c_eol = 0; c_eof = 0; c_err = 0; eof_pos = 0; sof_pos = 0;
    for (int i = seg_a; i < seg_b; i++) begin
      if (o_vld[i]) c_vld++;
      if (o_vld[i] && o_sof[i]) begin c_sof++; sof_pos = c_vld; end
      if (o_vld[i] && o_eol[i]) c_eol++;
      if (o_vld[i] && o_eof[i]) begin c_eof++; eof_pos = c_vld; end
      if (o_err[i]) c_err++;
    end
    check_eq("frame_pixels", c_vld, ROWS * COLS);
    check_eq("frame_sof_count", c_sof, 1);
    check_eq("frame_sof_pos", sof_pos, 1);
    check_eq("frame_eol_count", c_eol, ROWS);
    check_eq("frame_eof_count", c_eof, 1);
    check_eq("frame_eof_pos", eof_pos, ROWS * COLS);
    check_eq("frame_err_count", c_err, 0);

    // Asynchronous reset in the middle of a line
    in_train_done = 1'b1;
    drive(PFX); drive(10'h000); drive(PFX); drive(10'h001);
    for (int i = 0; i < 6; i++) drive(10'h020 + 10'(i));
    @(negedge clk);
    check_eq("pre_reset_valid", out_valid, 1);
    check_eq("pre_reset_locked", locked, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Without a fresh FS nothing may come out
    seen_vld = 0; seen_lck = 0;
    drive(PFX); drive(10'h001);
    for (int i = 0; i < 8; i++) begin
      drive(10'h040 + 10'(i));
      if (out_valid) seen_vld++;
      if (locked) seen_lck++;
    end
    drive(PFX); drive(10'h002);
    drive(PFX); drive(10'h000);
    if (out_valid) seen_vld++;
    drive(PFX); drive(10'h001);
    if (out_valid) seen_vld++;
    check_eq("no_fs_valid", seen_vld, 0);
    check_eq("no_fs_locked", seen_lck, 0);

    // After FS/LS pixels follow with three cycles of latency
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_eq($sformatf("post_reset_valid%0d", i), out_valid, (i >= 3));
      if (i >= 3) check_eq($sformatf("post_reset_data%0d", i), out_data, 10'h100 + 10'(i - 3));
      if (i == 3) check_eq("post_reset_sof", out_sof, 1);
      in_data = 10'h100 + 10'(i);
    end

`ifdef MT9V032_TIMING_STATS_EN
    // Three clean frames followed by one aborted by an unknown code
    @(negedge clk);
    rst_n = 1'b0;
    in_data = '0;
    in_train_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_words = 0;
    idle(3);
    for (int f = 0; f < 3; f++) gen_frame(0, 1'b0);
    gen_frame(3, 1'b0);
    idle(8);
    run_model();
    play_stream();
    check_eq("stat_frames", stat_frames, 3);
    check_eq("stat_errors", stat_errors, 1);
    check_eq("stat_cols", stat_cols, COLS);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
